// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave: register word offsets, CTRL
// field positions and the packed CTRL register layout.
package apb_timer_pkg;

    localparam int PS_W = 8;

    localparam logic [2:0] CTRL_OFS    = 3'd0;
    localparam logic [2:0] LOAD_OFS    = 3'd1;
    localparam logic [2:0] COUNT_OFS   = 3'd2;
    localparam logic [2:0] STATUS_OFS  = 3'd3;
    localparam logic [2:0] SCRATCH_OFS = 3'd4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_PS_LSB     = 8;

    localparam int STATUS_EXPIRED_BIT = 0;

    typedef struct packed {
        logic [PS_W-1:0] prescale;
        logic            irq_en;
        logic            reload;
        logic            en;
    } ctrl_t;

    // Bus view of CTRL; unimplemented bits read as zero.
    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]               = c.en;
        w[CTRL_RELOAD_BIT]           = c.reload;
        w[CTRL_IRQ_EN_BIT]           = c.irq_en;
        w[CTRL_PS_LSB +: PS_W]       = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB2 bus bundle between the bridge (master) and the timer slave.
// Handshake: setup phase is sel & !Penable, access phase is sel & Penable;
// every transfer completes in its access cycle (no wait states, no error).
interface apb_timer_if;

    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx,
        output Penable,
        output Pwrite,
        output Paddr,
        output Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx,
        input  Penable,
        input  Pwrite,
        input  Paddr,
        input  Pwdata,
        output Prdata
    );

endinterface

// File: rtl/apb_timer_prescaler.sv
// 8-bit prescaler: emits a one-cycle tick every (prescale+1) enabled cycles
// and sits at zero while disabled.
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic            Hclk,
    input  logic            Hresetn,
    input  logic            en,
    input  logic            restart,
    input  logic [PS_W-1:0] prescale,
    output logic            tick
);

    logic [PS_W-1:0] pc_q;
    logic [PS_W-1:0] pc_d;

    assign tick = en && (pc_q == prescale);

    // A prescale lowered below pc lets pc run on to its natural 8-bit wrap.
    always_comb begin
        pc_d = pc_q;
        if (!en || restart || tick) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: register file, read snapshot and a prescaled 32-bit
// down-counter with auto-reload, sticky expiry flag and level interrupt.
module apb_timer_slave #(
    parameter int          SEL_IDX  = 0,
    parameter logic [31:0] LOAD_RST = 32'h0000_0000
) (
    input  logic         Hclk,
    input  logic         Hresetn,
    apb_timer_if.slave   apb,
    output logic         Irq
);

    import apb_timer_pkg::*;

    logic        sel;
    logic        setup_rd;
    logic        wr_acc;
    logic [2:0]  idx;
    logic        ctrl_wr;
    logic        load_wr;
    logic        count_wr;
    logic        status_wr;
    logic        scratch_wr;
    logic        tick;
    logic        tick_eff;
    logic        restart;
    logic [31:0] rd_val;
    logic        unused_bits;

    ctrl_t       ctrl_q,    ctrl_d;
    logic [31:0] load_q,    load_d;
    logic [31:0] count_q,   count_d;
    logic        expired_q, expired_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] prdata_q,  prdata_d;

    assign sel      = apb.Pselx[SEL_IDX];
    assign setup_rd = sel && !apb.Penable && !apb.Pwrite;
    assign wr_acc   = sel &&  apb.Penable &&  apb.Pwrite;
    assign idx      = apb.Paddr[4:2];

    assign ctrl_wr    = wr_acc && (idx == CTRL_OFS);
    assign load_wr    = wr_acc && (idx == LOAD_OFS);
    assign count_wr   = wr_acc && (idx == COUNT_OFS);
    assign status_wr  = wr_acc && (idx == STATUS_OFS);
    assign scratch_wr = wr_acc && (idx == SCRATCH_OFS);

    assign unused_bits = ^{apb.Paddr[31:5], apb.Paddr[1:0], apb.Pselx};

    // A COUNT write, or a CTRL write that stops the timer, overrides the tick.
    assign tick_eff = tick && !count_wr && !(ctrl_wr && !apb.Pwdata[CTRL_EN_BIT]);
    assign restart  = ctrl_wr && apb.Pwdata[CTRL_EN_BIT] && !ctrl_q.en;

    apb_timer_prescaler u_prescaler (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .en       (ctrl_q.en),
        .restart  (restart),
        .prescale (ctrl_q.prescale),
        .tick     (tick)
    );

    always_comb begin
        rd_val = '0;
        case (idx)
            CTRL_OFS:    rd_val = ctrl_pack(ctrl_q);
            LOAD_OFS:    rd_val = load_q;
            COUNT_OFS:   rd_val = count_q;
            STATUS_OFS:  rd_val[STATUS_EXPIRED_BIT] = expired_q;
            SCRATCH_OFS: rd_val = scratch_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        scratch_d = scratch_q;

        // Snapshot at setup, drop to zero otherwise so slaves can be OR-ed.
        prdata_d = setup_rd ? rd_val : '0;

        // Clear first so an expiry on the same edge still sets the flag.
        if (status_wr && apb.Pwdata[STATUS_EXPIRED_BIT]) begin
            expired_d = 1'b0;
        end

        if (tick_eff) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q.reload) begin
                    count_d = load_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
        end

        if (ctrl_wr) begin
            ctrl_d.en       = apb.Pwdata[CTRL_EN_BIT];
            ctrl_d.reload   = apb.Pwdata[CTRL_RELOAD_BIT];
            ctrl_d.irq_en   = apb.Pwdata[CTRL_IRQ_EN_BIT];
            ctrl_d.prescale = apb.Pwdata[CTRL_PS_LSB +: PS_W];
        end
        if (load_wr) begin
            load_d = apb.Pwdata;
        end
        if (count_wr) begin
            count_d = apb.Pwdata;
        end
        if (scratch_wr) begin
            scratch_d = apb.Pwdata;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            ctrl_q    <= '0;
            load_q    <= LOAD_RST;
            count_q   <= LOAD_RST;
            expired_q <= 1'b0;
            scratch_q <= '0;
            prdata_q  <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            scratch_q <= scratch_d;
            prdata_q  <= prdata_d;
        end
    end

    assign apb.Prdata = prdata_q;
    assign Irq        = expired_q && ctrl_q.irq_en;

endmodule
